payoff_averager: RTL
====================

Name: payoff_averager

Overview:
- Downstream consumer of the Monte Carlo path generator in the option-pricing datapath.
- Takes the per-day price stream (unsigned fixed-point Q8.4, 12 bit), cuts it into paths of 2^LOG2_DAYS samples and computes each path's call payoff against a strike K.
- Supports European mode (last price) and Asian mode (arithmetic mean of the path).
- Averages payoffs over 2^LOG2_PATHS paths and emits one option price per run.

Parameters:
- LOG2_DAYS, 4, log2 of samples per path (days); path length = 2^LOG2_DAYS.
- LOG2_PATHS, 10, log2 of paths per run; path count = 2^LOG2_PATHS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse; begins a run; honoured only in IDLE.
- mode  input  1  0 = European, 1 = Asian; latched on accepted start.
- strike  input  12  strike K, Q8.4; latched on accepted start.
- in_valid  input  1  a price sample is present this cycle (path generator valid).
- in_path  input  12  price sample, Q8.4 unsigned.
- busy  output  1  high in RUN and DONE.
- price_valid  output  1  one-cycle pulse when price is final.
- price  output  12  mean payoff, Q8.4; holds its value until the next accepted start.

Behaviour:
- Reset values: FSM = IDLE; day_cnt, path_cnt, day_sum, acc = 0; busy = 0, price_valid = 0, price = 0. Reset is asynchronous and can abort a run at any point.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1: latch mode and strike, clear the counters, day_sum, acc and price, then go to RUN.
  - in_valid is ignored.
- RUN, per cycle with in_valid=1 (one sample accepted per valid cycle; in_valid=0 cycles stall with no state change):
  - Non-last day:
    - day_cnt increments.
    - Asian mode: day_sum += in_path (width 12+LOG2_DAYS).
  - Last day (day_cnt == 2^LOG2_DAYS-1):
    - Path value v: European v = in_path; Asian v = (day_sum + in_path) >> LOG2_DAYS, truncated (result fits in 12 bit).
    - Payoff p = (v > strike) ? v - strike : 0, 12-bit unsigned. v == strike gives 0.
    - acc += p (width 12+LOG2_PATHS; cannot overflow).
    - day_cnt and day_sum clear; path_cnt increments.
  - If path_cnt == 2^LOG2_PATHS-1 on that last day: go to DONE.
- DONE (exactly one cycle):
  - price_valid = 1, price = acc >> LOG2_PATHS (registered, truncated).
  - Next state is IDLE.
  - Latency: price_valid is asserted in the cycle after the final sample is accepted.
- start while busy: ignored, no effect.
- in_valid in IDLE or DONE: sample is dropped.
- Counters wrap only by explicit clear; no partial-path output exists.
- Reset mid-run: all state cleared, no price_valid pulse; the next start runs cleanly.

Decomposition:
- Shared option-pricing package holds:
  - Q8.4 width constant (12) and fraction-bit constant (4).
  - FSM state encoding.
  - Mode constants MODE_EURO=0, MODE_ASIAN=1.
- One sub-module, payoff_calc: combinational; inputs v and strike; output 12-bit max(v-strike,0). It is reused later for puts by swapping operands.
- Counters, accumulators and FSM stay in payoff_averager.

Test Plan (LOG2_DAYS=2, LOG2_PATHS=2 unless noted):
- European: strike=0x640; last-day samples of the 4 paths = 0x6A0, 0x600, 0x640, 0x700 -> payoffs 0x60, 0, 0, 0xC0 -> price=0x048, single price_valid pulse one cycle after the 16th sample, busy low the following cycle.
- Asian: strike=0x640; every path = 0x600, 0x640, 0x680, 0x6C0 -> mean 0x660 -> payoff 0x20 -> price=0x020.
- Gapped input: repeat the European run with random in_valid=0 cycles inserted, and toggle start while busy -> identical price=0x048; start ignored.
- Boundaries:
  - All samples 0x500 with strike=0x640 -> price=0x000.
  - strike=0x000 with all samples 0xFFF, both modes -> price=0xFFF (no overflow).
- Reset mid-run: assert rst_n=0 after 7 samples -> busy=0, price=0, no pulse. Then a fresh European run -> price=0x048.
- Default parameters (16 days x 1024 paths): every path constant 0x6A0, strike=0x640 -> price=0x060 after 16384 accepted samples.

Source files
------------

// File: rtl/payoff_averager_pkg.sv
// Shared option-pricing definitions used by the payoff datapath.
//   QW / QFRAC        : Q8.4 price word width and number of fraction bits
//   state_e           : payoff_averager FSM encoding
//   MODE_EURO/ASIAN   : payoff mode selector values
package payoff_averager_pkg;

  localparam int unsigned QW    = 12;
  localparam int unsigned QFRAC = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic MODE_EURO  = 1'b0;
  localparam logic MODE_ASIAN = 1'b1;

endpackage

// File: rtl/payoff_averager_payoff_calc.sv
// Call payoff max(v - strike, 0) on Q8.4 unsigned words. Purely combinational;
// swapping the operands gives the put payoff.
//   v      : path value (price), Q8.4
//   strike : strike K, Q8.4
//   payoff : max(v - strike, 0), Q8.4
module payoff_calc
  import payoff_averager_pkg::*;
(
  input  logic [QW-1:0] v,
  input  logic [QW-1:0] strike,
  output logic [QW-1:0] payoff
);

  always_comb begin
    payoff = (v > strike) ? (v - strike) : '0;
  end

endmodule

// File: rtl/payoff_averager.sv
// Cuts the per-day price stream into paths of 2^LOG2_DAYS samples, computes each
// path's call payoff (European: last price, Asian: truncated path mean) and
// emits the mean payoff over 2^LOG2_PATHS paths as one option price per run.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle run request, honoured only when idle
//   mode        : 0 European, 1 Asian (latched on start)
//   strike      : strike K, Q8.4 (latched on start)
//   in_valid    : price sample present this cycle
//   in_path     : price sample, Q8.4 unsigned
//   busy        : run in progress (RUN and DONE)
//   price_valid : one-cycle pulse, price is final
//   price       : mean payoff, Q8.4, held until the next accepted start
module payoff_averager
  import payoff_averager_pkg::*;
#(
  parameter int unsigned LOG2_DAYS  = 4,
  parameter int unsigned LOG2_PATHS = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [QW-1:0] strike,
  input  logic          in_valid,
  input  logic [QW-1:0] in_path,
  output logic          busy,
  output logic          price_valid,
  output logic [QW-1:0] price
);

  localparam int unsigned SumW = QW + LOG2_DAYS;
  localparam int unsigned AccW = QW + LOG2_PATHS;

  state_e                state_q;
  logic                  mode_q;
  logic [QW-1:0]         strike_q;
  logic [LOG2_DAYS-1:0]  day_cnt_q;
  logic [LOG2_PATHS-1:0] path_cnt_q;
  logic [SumW-1:0]       day_sum_q;
  logic [AccW-1:0]       acc_q;
  logic                  busy_q;
  logic                  price_valid_q;
  logic [QW-1:0]         price_q;

  logic                  last_day;
  logic                  last_path;
  logic [SumW-1:0]       sum_full;
  logic [QW-1:0]         path_v;
  logic [QW-1:0]         payoff;
  logic [AccW-1:0]       acc_next;

  always_comb begin
    last_day  = &day_cnt_q;
    last_path = &path_cnt_q;
    // The full path sum cannot exceed SumW bits, so the mean always fits in QW.
    sum_full  = day_sum_q + SumW'(in_path);
    path_v    = (mode_q == MODE_ASIAN) ? sum_full[SumW-1:LOG2_DAYS] : in_path;
    acc_next  = acc_q + AccW'(payoff);
  end

  payoff_calc u_payoff_calc (
    .v      (path_v),
    .strike (strike_q),
    .payoff (payoff)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      mode_q        <= MODE_EURO;
      strike_q      <= '0;
      day_cnt_q     <= '0;
      path_cnt_q    <= '0;
      day_sum_q     <= '0;
      acc_q         <= '0;
      busy_q        <= 1'b0;
      price_valid_q <= 1'b0;
      price_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mode_q     <= mode;
            strike_q   <= strike;
            day_cnt_q  <= '0;
            path_cnt_q <= '0;
            day_sum_q  <= '0;
            acc_q      <= '0;
            price_q    <= '0;
            busy_q     <= 1'b1;
            state_q    <= StRun;
          end
        end
        StRun: begin
          if (in_valid) begin
            if (last_day) begin
              day_cnt_q  <= '0;
              day_sum_q  <= '0;
              path_cnt_q <= path_cnt_q + LOG2_PATHS'(1);
              acc_q      <= acc_next;
              if (last_path) begin
                price_valid_q <= 1'b1;
                price_q       <= acc_next[AccW-1:LOG2_PATHS];
                state_q       <= StDone;
              end
            end else begin
              day_cnt_q <= day_cnt_q + LOG2_DAYS'(1);
              if (mode_q == MODE_ASIAN) begin
                day_sum_q <= sum_full;
              end
            end
          end
        end
        StDone: begin
          price_valid_q <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign price_valid = price_valid_q;
  assign price       = price_q;

endmodule
